tri_inv_pipe: RTL and testbench

//  Parametrised successor to the single-gate inverter primitive: WIDTH-bit data path with per-bit

---
 rtl/tri_inv_pipe.sv | 127 ++++++++++++
 tb/tb_tri_inv_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_inv_pipe.sv
// Per-bit programmable inverter carried through a DEPTH-stage elastic valid/ready pipeline; optional parity via TRI_INV_PIPE_PARITY_EN.
// Latency: DEPTH cycles from accept to out_vld when unblocked, one beat per cycle sustained.
// Backpressure: out_rdy=0 holds the last stage; bubbles collapse and in_rdy drops only when every stage is held.
module tri_inv_pipe #(
    parameter int               WIDTH        = 1,
    parameter int               DEPTH        = 2,
    parameter logic [0:WIDTH-1] INV_MASK_RST = '1,
    parameter int               CNT_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [0:WIDTH-1]   in_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [0:WIDTH-1]   out_data,
    input  logic               mask_we,
    input  logic [0:WIDTH-1]   mask_wdata,
    output logic [0:WIDTH-1]   mask_q,
    input  logic               flush,
    output logic [CNT_W-1:0]   occ,
    output logic               empty,
`ifdef TRI_INV_PIPE_PARITY_EN
    output logic               full,
    input  logic               par_err_inj,
    output logic               out_par
`else
    output logic               full
`endif
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("tri_inv_pipe: DEPTH must be 1..8");
    end
    if ($clog2(DEPTH + 1) > CNT_W) begin : g_bad_cnt_w
        $error("tri_inv_pipe: CNT_W too narrow for DEPTH");
    end

    logic [DEPTH-1:0]   stg_vld;
    logic [0:WIDTH-1]   stg_dat [DEPTH];
    logic [DEPTH-1:0]   adv;
    logic [DEPTH-1:0]   load;
    logic               accept;
    logic               consume;
    logic [0:WIDTH-1]   in_inv;

    // adv[k]: stage k hands its beat downstream this cycle; resolved from the output end back.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = stg_vld[DEPTH-1] & out_rdy;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = stg_vld[k] & (~stg_vld[k+1] | adv[k+1]);
        end
    end

    assign in_rdy  = rst_n & ~flush & (~stg_vld[0] | adv[0]);
    assign accept  = in_vld & in_rdy;
    assign consume = adv[DEPTH-1];
    assign in_inv  = in_data ^ mask_q;

    always_comb begin
        load    = '0;
        load[0] = accept;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            occ     <= '0;
            mask_q  <= INV_MASK_RST;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dat[k] <= '0;
            end
        end else begin
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            if (flush) begin
                stg_vld <= '0;
                occ     <= '0;
            end else begin
                stg_vld <= load | (stg_vld & ~adv);
                occ     <= occ + CNT_W'(accept) - CNT_W'(consume);
            end
            // Data of invalid stages is don't-care, so shifting during flush is harmless.
            if (accept) begin
                stg_dat[0] <= in_inv;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    stg_dat[k] <= stg_dat[k-1];
                end
            end
        end
    end

`ifdef TRI_INV_PIPE_PARITY_EN
    logic [DEPTH-1:0] stg_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_par <= '0;
        end else begin
            if (accept) begin
                stg_par[0] <= (^in_inv) ^ par_err_inj;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    stg_par[k] <= stg_par[k-1];
                end
            end
        end
    end

    assign out_par = stg_par[DEPTH-1];
`endif

    assign out_vld  = stg_vld[DEPTH-1];
    assign out_data = stg_dat[DEPTH-1];
    assign empty    = (occ == '0);
    assign full     = (occ == CNT_W'(DEPTH));

endmodule

// File: tb/tb_tri_inv_pipe.sv
// Bench for tri_inv_pipe: DEPTH=2 and DEPTH=4 instances driven in lockstep, checked against a
// per-beat queue model (beat leaves DEPTH cycles after accept if at head; in_rdy = room or consume).
module tb_tri_inv_pipe;

    typedef struct {
        logic [7:0] dat;
        logic       par;
        int         t;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_rdy;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       flush;
    logic       par_err_inj;

    logic       rdy     [2];
    logic       ovld    [2];
    logic [7:0] odat    [2];
    logic [7:0] mq_w    [2];
    logic [3:0] occ_w   [2];
    logic       empty_w [2];
    logic       full_w  [2];
    logic       opar    [2];

    int         n_cmp;
    int         n_bad;
    int         cyc;
    logic [7:0] m_mask;
    beat_t      mq [2][$];
    logic [7:0] lg_dat[$];
    int         lg_t[$];
    logic       lg_par[$];

`ifdef TRI_INV_PIPE_PARITY_EN
    tri_inv_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK_RST(8'hFF), .CNT_W(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy[0]), .in_data(in_data),
        .out_vld(ovld[0]), .out_rdy(out_rdy), .out_data(odat[0]), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mq_w[0]), .flush(flush), .occ(occ_w[0]),
        .empty(empty_w[0]), .full(full_w[0]), .par_err_inj(par_err_inj), .out_par(opar[0]));
    tri_inv_pipe #(.WIDTH(8), .DEPTH(4), .INV_MASK_RST(8'hFF), .CNT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy[1]), .in_data(in_data),
        .out_vld(ovld[1]), .out_rdy(out_rdy), .out_data(odat[1]), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mq_w[1]), .flush(flush), .occ(occ_w[1]),
        .empty(empty_w[1]), .full(full_w[1]), .par_err_inj(par_err_inj), .out_par(opar[1]));
`else
    tri_inv_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK_RST(8'hFF), .CNT_W(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy[0]), .in_data(in_data),
        .out_vld(ovld[0]), .out_rdy(out_rdy), .out_data(odat[0]), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mq_w[0]), .flush(flush), .occ(occ_w[0]),
        .empty(empty_w[0]), .full(full_w[0]));
    tri_inv_pipe #(.WIDTH(8), .DEPTH(4), .INV_MASK_RST(8'hFF), .CNT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy[1]), .in_data(in_data),
        .out_vld(ovld[1]), .out_rdy(out_rdy), .out_data(odat[1]), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mq_w[1]), .flush(flush), .occ(occ_w[1]),
        .empty(empty_w[1]), .full(full_w[1]));
    assign opar[0] = 1'b0;
    assign opar[1] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge with inputs already applied: check, update model, advance one cycle.
    task automatic step();
        #1;
        if (!rst_n) begin
            mq[0].delete();
            mq[1].delete();
            m_mask = 8'hFF;
        end
        for (int i = 0; i < 2; i++) begin
            int    dep;
            logic  ev;
            logic  er;
            beat_t b;
            dep = (i == 0) ? 2 : 4;
            ev  = (mq[i].size() > 0) && ((cyc - mq[i][0].t) >= dep);
            er  = rst_n && !flush && ((mq[i].size() < dep) || (ev && out_rdy));
            chk($sformatf("d%0d_in_rdy", dep), 32'(rdy[i]), 32'(er));
            chk($sformatf("d%0d_out_vld", dep), 32'(ovld[i]), 32'(ev));
            chk($sformatf("d%0d_occ", dep), 32'(occ_w[i]), 32'(mq[i].size()));
            chk($sformatf("d%0d_empty", dep), 32'(empty_w[i]), 32'(mq[i].size() == 0));
            chk($sformatf("d%0d_full", dep), 32'(full_w[i]), 32'(mq[i].size() == dep));
            chk($sformatf("d%0d_mask_q", dep), 32'(mq_w[i]), 32'(m_mask));
            if (ev) begin
                chk($sformatf("d%0d_out_data", dep), 32'(odat[i]), 32'(mq[i][0].dat));
`ifdef TRI_INV_PIPE_PARITY_EN
                chk($sformatf("d%0d_out_par", dep), 32'(opar[i]), 32'(mq[i][0].par));
`endif
            end
            if (!rst_n) begin
                chk($sformatf("d%0d_rst_data", dep), 32'(odat[i]), 32'h0);
            end
            if (i == 0 && ev && out_rdy && rst_n) begin
                lg_dat.push_back(odat[0]);
                lg_t.push_back(cyc);
                lg_par.push_back(opar[0]);
            end
            if (rst_n) begin
                if (flush) begin
                    mq[i].delete();
                end else begin
                    if (ev && out_rdy) void'(mq[i].pop_front());
                    if (in_vld && er) begin
                        b.dat = in_data ^ m_mask;
                        b.par = (^(in_data ^ m_mask)) ^ par_err_inj;
                        b.t   = cyc;
                        mq[i].push_back(b);
                    end
                end
            end
        end
        if (rst_n && mask_we) m_mask = mask_wdata;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_vld  = 1'b0;
        mask_we = 1'b0;
        flush   = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push(input logic [7:0] d);
        in_vld  = 1'b1;
        in_data = d;
        step();
        in_vld  = 1'b0;
    endtask

    initial begin
        int t0;
        n_cmp = 0; n_bad = 0; cyc = 0; m_mask = 8'hFF;
        rst_n = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b1;
        mask_we = 1'b0; mask_wdata = 8'h00; flush = 1'b0; par_err_inj = 1'b0;
        @(negedge clk);

        // Reset: in_rdy low, outputs idle, mask at all-ones.
        in_vld = 1'b1;
        for (int k = 0; k < 3; k++) step();
        in_vld = 1'b0;
        rst_n  = 1'b1;
        idle(2);

        // Back-to-back stream, one output per cycle at accept+2.
        lg_dat.delete(); lg_t.delete(); lg_par.delete();
        t0 = cyc;
        push(8'h00); push(8'hA5); push(8'h0F);
        idle(4);
        chk("stream_count", 32'(lg_dat.size()), 32'd3);
        if (lg_dat.size() == 3) begin
            chk("stream_d0", 32'(lg_dat[0]), 32'hFF);
            chk("stream_d1", 32'(lg_dat[1]), 32'h5A);
            chk("stream_d2", 32'(lg_dat[2]), 32'hF0);
            chk("stream_t0", 32'(lg_t[0] - t0), 32'd2);
            chk("stream_t2", 32'(lg_t[2] - t0), 32'd4);
        end

        // Back-pressure: only two of three fit in DEPTH=2, then drain 2,1,0.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'h11 * 8'(k + 1);
            step();
        end
        in_vld = 1'b0;
        #1;
        chk("bp_occ", 32'(occ_w[0]), 32'd2);
        chk("bp_full", 32'(full_w[0]), 32'd1);
        chk("bp_in_rdy", 32'(rdy[0]), 32'd0);
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_drain_occ", 32'(occ_w[0]), 32'(2 - k));
            step();
        end
        idle(6);

        // Mask write racing an accept: that beat still sees the old mask.
        lg_dat.delete(); lg_t.delete(); lg_par.delete();
        mask_we = 1'b1; mask_wdata = 8'h0F;
        push(8'h00);
        mask_we = 1'b0;
        push(8'h00);
        idle(4);
        chk("mask_count", 32'(lg_dat.size()), 32'd2);
        if (lg_dat.size() == 2) begin
            chk("mask_old", 32'(lg_dat[0]), 32'hFF);
            chk("mask_new", 32'(lg_dat[1]), 32'h0F);
        end

        // Flush with three beats in the DEPTH=4 instance; none may emerge.
        out_rdy = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        in_vld = 1'b1; in_data = 8'h04; flush = 1'b1;
        #1;
        chk("flush_in_rdy", 32'(rdy[1]), 32'd0);
        chk("flush_pre_occ", 32'(occ_w[1]), 32'd3);
        step();
        in_vld = 1'b0; flush = 1'b0;
        #1;
        chk("flush_occ", 32'(occ_w[1]), 32'd0);
        chk("flush_out_vld", 32'(ovld[1]), 32'd0);
        idle(8);

`ifdef TRI_INV_PIPE_PARITY_EN
        lg_dat.delete(); lg_t.delete(); lg_par.delete();
        mask_we = 1'b1; mask_wdata = 8'h00;
        step();
        mask_we = 1'b0;
        push(8'h01);
        par_err_inj = 1'b1;
        push(8'h01);
        par_err_inj = 1'b0;
        idle(4);
        chk("par_count", 32'(lg_par.size()), 32'd2);
        if (lg_par.size() == 2) begin
            chk("par_clean", 32'(lg_par[0]), 32'd1);
            chk("par_inj", 32'(lg_par[1]), 32'd0);
        end
`endif

        // Randomised traffic with stalls, flushes, mask writes and rare async resets.
        for (int n = 0; n < 3000; n++) begin
            in_vld      = ($urandom_range(0, 3) != 0);
            in_data     = 8'($urandom);
            out_rdy     = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 49) == 0);
            mask_we     = ($urandom_range(0, 19) == 0);
            mask_wdata  = 8'($urandom);
            par_err_inj = ($urandom_range(0, 7) == 0);
            rst_n       = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        par_err_inj = 1'b0;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
